keccak_clkgate_ctrl: RTL and testbench



---
 rtl/keccak_cg_pkg.sv | 20 ++
 rtl/keccak_cg_sat_cnt.sv | 26 ++
 rtl/keccak_clkgate_ctrl.sv | 115 +++++++++++
 tb/tb_keccak_clkgate_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/keccak_cg_pkg.sv
// Shared types and constants for the Keccak clock-gate sequencing controller.
package keccak_cg_pkg;

   typedef enum logic [1:0] {
      GATED  = 2'd0,
      WAKE   = 2'd1,
      ACTIVE = 2'd2
   } cg_state_e;

   localparam int STATS_W = 32;

   // Wake counter must hold WAKE_CYCLES; never narrower than one bit.
   function automatic int wake_cnt_w(input int wake_cycles);
      int w;
      w = $clog2(wake_cycles + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage : keccak_cg_pkg

// File: rtl/keccak_cg_sat_cnt.sv
// Up-counter with synchronous clear (priority) that sticks at all-ones instead of wrapping.
module keccak_cg_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (&v) ? v : v + W'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i) begin
         cnt_o <= sat_inc(cnt_o);
      end
   end

endmodule : keccak_cg_sat_cnt

// File: rtl/keccak_clkgate_ctrl.sv
// Clock-gate enable sequencer for the Keccak core: wake, settle, grant, idle-gate.
// Optional gated-cycle statistics counter is enabled by defining KECCAK_CG_STATS_EN.
module keccak_clkgate_ctrl
   import keccak_cg_pkg::*;
#(
   parameter int WAKE_CYCLES = 2,
   parameter int IDLE_W      = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_req_i,
   output logic               start_gnt_o,
   input  logic               core_busy_i,
   input  logic [IDLE_W-1:0]  cfg_idle_cycles_i,
   input  logic               cfg_cg_disable_i,
   output logic               clk_en_o,
   output logic               gated_o,
   input  logic               stats_clr_i,
   output logic [STATS_W-1:0] gated_cycles_o
);

   localparam int WCW = wake_cnt_w(WAKE_CYCLES);
   localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_CYCLES);

   cg_state_e         state_q, state_d;
   logic [WCW-1:0]    wake_cnt_q;
   logic [IDLE_W-1:0] idle_cnt;
   logic              idle_cyc;
   logic              go_gated;
   logic              wake_ld;
   logic              idle_inc;
   logic              idle_clr;

   assign idle_cyc = ~start_req_i & ~core_busy_i;

   always_comb begin
      state_d     = state_q;
      start_gnt_o = 1'b0;
      go_gated    = 1'b0;
      wake_ld     = 1'b0;
      case (state_q)
         GATED: begin
            if (start_req_i || cfg_cg_disable_i) begin
               state_d = WAKE;
               wake_ld = 1'b1;
            end
         end
         WAKE: begin
            if (wake_cnt_q == '0) state_d = ACTIVE;
         end
         ACTIVE: begin
            start_gnt_o = start_req_i & ~core_busy_i;
            // A request on the threshold cycle is not idle, so it is granted instead of gating.
            if (idle_cyc && (idle_cnt == cfg_idle_cycles_i) && !cfg_cg_disable_i) begin
               state_d  = GATED;
               go_gated = 1'b1;
            end
         end
         default: state_d = GATED;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= GATED;
         clk_en_o <= 1'b0;
      end else begin
         state_q  <= state_d;
         clk_en_o <= (state_d != GATED);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wake_cnt_q <= '0;
      end else if (wake_ld) begin
         wake_cnt_q <= WAKE_LOAD;
      end else if ((state_q == WAKE) && (wake_cnt_q != '0)) begin
         wake_cnt_q <= wake_cnt_q - WCW'(1);
      end
   end

   assign gated_o = (state_q == GATED);

   // Held at zero while gating is disabled so counting restarts cleanly when it is re-enabled.
   assign idle_inc = (state_q == ACTIVE) & idle_cyc;
   assign idle_clr = (state_q != ACTIVE) | ~idle_cyc | cfg_cg_disable_i | go_gated;

   keccak_cg_sat_cnt #(
      .W(IDLE_W)
   ) u_idle_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (idle_clr),
      .inc_i  (idle_inc),
      .cnt_o  (idle_cnt)
   );

`ifdef KECCAK_CG_STATS_EN
   keccak_cg_sat_cnt #(
      .W(STATS_W)
   ) u_stats_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (stats_clr_i),
      .inc_i  (~clk_en_o),
      .cnt_o  (gated_cycles_o)
   );
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr_i;
   assign gated_cycles_o   = '0;
`endif

endmodule : keccak_clkgate_ctrl

// File: tb/tb_keccak_clkgate_ctrl.sv
// Directed, table-driven bench for keccak_clkgate_ctrl (WAKE_CYCLES=2, IDLE_W=8).
module tb_keccak_clkgate_ctrl;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_req_i = 1'b0;
   logic        start_gnt_o;
   logic        core_busy_i = 1'b0;
   logic [7:0]  cfg_idle_cycles_i = 8'd3;
   logic        cfg_cg_disable_i = 1'b0;
   logic        clk_en_o;
   logic        gated_o;
   logic        stats_clr_i = 1'b0;
   logic [31:0] gated_cycles_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   keccak_clkgate_ctrl #(
      .WAKE_CYCLES(2),
      .IDLE_W(8)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_ni),
      .start_req_i       (start_req_i),
      .start_gnt_o       (start_gnt_o),
      .core_busy_i       (core_busy_i),
      .cfg_idle_cycles_i (cfg_idle_cycles_i),
      .cfg_cg_disable_i  (cfg_cg_disable_i),
      .clk_en_o          (clk_en_o),
      .gated_o           (gated_o),
      .stats_clr_i       (stats_clr_i),
      .gated_cycles_o    (gated_cycles_o)
   );

   typedef struct {
      logic       req;
      logic       busy;
      logic       dis;
      logic [7:0] cfg;
      logic       gnt;
      logic       en;
      logic       gated;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic req, input logic busy, input logic dis, input logic [7:0] cfg,
                      input logic gnt, input logic en, input logic gated);
      vec_t v;
      v.req = req; v.busy = busy; v.dis = dis; v.cfg = cfg;
      v.gnt = gnt; v.en = en; v.gated = gated;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic gnt, input logic en, input logic gated);
      chk({tag, " gnt"},   32'(start_gnt_o), 32'(gnt));
      chk({tag, " en"},    32'(clk_en_o),    32'(en));
      chk({tag, " gated"}, 32'(gated_o),     32'(gated));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   int exp_stats;

   initial begin
      // req busy dis cfg | gnt en gated
      add(1, 0, 0, 3, 0, 0, 1);                               // c0  GATED, request seen
      repeat (3) add(1, 0, 0, 3, 0, 1, 0);                    // c1-3 WAKE, no grant
      add(1, 0, 0, 3, 1, 1, 0);                               // c4  ACTIVE grant
      repeat (4) add(0, 0, 0, 3, 0, 1, 0);                    // c5-8 idle 0..3
      add(0, 0, 0, 3, 0, 0, 1);                               // c9  GATED
      add(1, 1, 0, 3, 0, 0, 1);                               // c10 req while busy
      repeat (9) add(1, 1, 0, 3, 0, 1, 0);                    // c11-19 wake + busy
      add(1, 0, 0, 3, 1, 1, 0);                               // c20 busy falls -> grant
      repeat (3) add(0, 0, 0, 3, 0, 1, 0);                    // c21-23 idle 0..2
      add(1, 0, 0, 3, 1, 1, 0);                               // c24 req on threshold
      repeat (4) add(0, 0, 0, 3, 0, 1, 0);                    // c25-28 idle restarts
      add(0, 0, 0, 3, 0, 0, 1);                               // c29 GATED
      add(1, 0, 0, 0, 0, 0, 1);                               // c30 cfg=0 case
      repeat (3) add(1, 0, 0, 0, 0, 1, 0);                    // c31-33 WAKE
      add(1, 0, 0, 0, 1, 1, 0);                               // c34 grant
      add(0, 0, 0, 0, 0, 1, 0);                               // c35 first idle -> gate
      add(0, 0, 0, 0, 0, 0, 1);                               // c36 GATED

      repeat (3) @(posedge clk);
      #1;
      chk_outs("reset", 1'b0, 1'b0, 1'b1);
      chk("reset stats", gated_cycles_o, 32'd0);
      rst_ni = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         start_req_i       = vecs[i].req;
         core_busy_i       = vecs[i].busy;
         cfg_cg_disable_i  = vecs[i].dis;
         cfg_idle_cycles_i = vecs[i].cfg;
         @(negedge clk);
         chk_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].en, vecs[i].gated);
         next_cycle();
      end

      // Gating disabled from GATED with no request: wake and hold for 1000 idle cycles.
      start_req_i = 1'b0; core_busy_i = 1'b0; cfg_idle_cycles_i = 8'd3; cfg_cg_disable_i = 1'b1;
      @(negedge clk);
      chk_outs("dis start", 1'b0, 1'b0, 1'b1);
      next_cycle();
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         chk_outs($sformatf("dis hold%0d", i), 1'b0, 1'b1, 1'b0);
         next_cycle();
      end
      cfg_cg_disable_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_outs($sformatf("dis off idle%0d", i), 1'b0, 1'b1, 1'b0);
         next_cycle();
      end
      @(negedge clk);
      chk_outs("dis off gated", 1'b0, 1'b0, 1'b1);
      next_cycle();

      // Asynchronous reset in the middle of WAKE.
      start_req_i = 1'b1;
      @(negedge clk);
      chk_outs("rw gated", 1'b0, 1'b0, 1'b1);
      next_cycle();
      @(negedge clk);
      chk_outs("rw wake", 1'b0, 1'b1, 1'b0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk_outs("rw async", 1'b0, 1'b0, 1'b1);
      chk("rw stats", gated_cycles_o, 32'd0);
      start_req_i = 1'b0;
      next_cycle();
      rst_ni = 1'b1;

      // 50 gated cycles, then a clear that coincides with an increment.
`ifdef KECCAK_CG_STATS_EN
      exp_stats = 50;
`else
      exp_stats = 0;
`endif
      repeat (50) @(posedge clk);
      @(negedge clk);
      chk_outs("stats gated", 1'b0, 1'b0, 1'b1);
      chk("stats count", gated_cycles_o, 32'(exp_stats));
      stats_clr_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stats clear", gated_cycles_o, 32'd0);
      stats_clr_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
`ifdef KECCAK_CG_STATS_EN
      exp_stats = 1;
`else
      exp_stats = 0;
`endif
      chk("stats resume", gated_cycles_o, 32'(exp_stats));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_keccak_clkgate_ctrl
